// File: rtl/veer_trace_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : veer_trace_collector
// Purpose  : Unpacks 3-slot retirement trace packets into per-instruction
//            records, buffers them in a FIFO and drains one per cycle over a
//            valid/ready stream. Packets that do not fit are dropped whole.
// Revision : 1.0 - initial release
// ============================================================================
module veer_trace_collector #(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [2:0]            trace_rv_i_valid_ip,
  input  logic [95:0]           trace_rv_i_insn_ip,
  input  logic [95:0]           trace_rv_i_address_ip,
  input  logic [2:0]            trace_rv_i_exception_ip,
  input  logic [4:0]            trace_rv_i_ecause_ip,
  input  logic [2:0]            trace_rv_i_interrupt_ip,
  input  logic [31:0]           trace_rv_i_tval_ip,
  input  logic                  trace_flush,
  input  logic                  drop_clr,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [31:0]           rec_insn,
  output logic [31:0]           rec_addr,
  output logic                  rec_exc,
  output logic                  rec_intr,
  output logic [4:0]            rec_ecause,
  output logic [31:0]           rec_tval,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } rec_t;

  rec_t                  mem_q [DEPTH];
  rec_t                  mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [1:0]  pkt_n;
  logic [AW:0] free_slots;
  logic        pkt_fits;
  logic        push;
  logic        drop;
  logic        pop;
  rec_t        slot_rec [3];
  logic [1:0]  slot_off [3];
  rec_t        head;

  // Packet sizing and accept/drop/pop decisions, all against start-of-cycle count
  always_comb begin
    pkt_n      = {1'b0, trace_rv_i_valid_ip[0]} + {1'b0, trace_rv_i_valid_ip[1]}
               + {1'b0, trace_rv_i_valid_ip[2]};
    free_slots = DEPTH_C - count_q;
    pkt_fits   = ((AW+1)'(pkt_n) <= free_slots);
    push       = (pkt_n != 2'd0) && pkt_fits && !trace_flush;
    drop       = !pkt_fits && !trace_flush;
    pop        = (count_q != '0) && rec_ready && !trace_flush;
  end

  // Build one record per slot and its compacted offset (valid slots below it)
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      slot_rec[k].insn   = trace_rv_i_insn_ip[32*k +: 32];
      slot_rec[k].addr   = trace_rv_i_address_ip[32*k +: 32];
      slot_rec[k].exc    = trace_rv_i_exception_ip[k];
      slot_rec[k].intr   = trace_rv_i_interrupt_ip[k];
      slot_rec[k].ecause = (trace_rv_i_exception_ip[k] | trace_rv_i_interrupt_ip[k])
                           ? trace_rv_i_ecause_ip : 5'd0;
      slot_rec[k].tval   = (trace_rv_i_exception_ip[k] | trace_rv_i_interrupt_ip[k])
                           ? trace_rv_i_tval_ip : 32'd0;
    end
    slot_off[0] = 2'd0;
    slot_off[1] = {1'b0, trace_rv_i_valid_ip[0]};
    slot_off[2] = {1'b0, trace_rv_i_valid_ip[0]} + {1'b0, trace_rv_i_valid_ip[1]};
  end

  // Next-state for FIFO storage, pointers and count; flush overrides everything
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (trace_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        for (int k = 0; k < 3; k++) begin
          if (trace_rv_i_valid_ip[k]) begin
            mem_d[wr_ptr_q + AW'(slot_off[k])] = slot_rec[k];
          end
        end
        wr_ptr_d = wr_ptr_q + AW'(pkt_n);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (push ? (AW+1)'(pkt_n) : '0) - (pop ? (AW+1)'(1) : '0);
    end
  end

  // Drop accounting: clear takes effect first so a same-cycle drop counts as one
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      overflow_d = drop;
      drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head-of-queue record, forced to zero while the FIFO is empty
  always_comb begin
    rec_valid  = (count_q != '0);
    head       = mem_q[rd_ptr_q];
    rec_insn   = rec_valid ? head.insn   : 32'd0;
    rec_addr   = rec_valid ? head.addr   : 32'd0;
    rec_exc    = rec_valid ? head.exc    : 1'b0;
    rec_intr   = rec_valid ? head.intr   : 1'b0;
    rec_ecause = rec_valid ? head.ecause : 5'd0;
    rec_tval   = rec_valid ? head.tval   : 32'd0;
    overflow   = overflow_q;
    drop_cnt   = drop_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_veer_trace_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_veer_trace_collector
// Purpose  : Directed self-checking bench for veer_trace_collector
//            (DEPTH = 8, DROP_CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_veer_trace_collector;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [2:0]  v_ip = '0;
  logic [95:0] insn_ip = '0;
  logic [95:0] addr_ip = '0;
  logic [2:0]  exc_ip = '0;
  logic [4:0]  ecause_ip = '0;
  logic [2:0]  intr_ip = '0;
  logic [31:0] tval_ip = '0;
  logic        flush = 1'b0;
  logic        drop_clr = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [31:0] rec_insn, rec_addr, rec_tval;
  logic        rec_exc, rec_intr, overflow;
  logic [4:0]  rec_ecause;
  logic [3:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  veer_trace_collector #(.DEPTH(8), .DROP_CNT_W(4)) dut (
    .clk(clk), .rst_l(rst_l),
    .trace_rv_i_valid_ip(v_ip), .trace_rv_i_insn_ip(insn_ip),
    .trace_rv_i_address_ip(addr_ip), .trace_rv_i_exception_ip(exc_ip),
    .trace_rv_i_ecause_ip(ecause_ip), .trace_rv_i_interrupt_ip(intr_ip),
    .trace_rv_i_tval_ip(tval_ip), .trace_flush(flush), .drop_clr(drop_clr),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_insn(rec_insn),
    .rec_addr(rec_addr), .rec_exc(rec_exc), .rec_intr(rec_intr),
    .rec_ecause(rec_ecause), .rec_tval(rec_tval), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a packet: insn words i0..i2, PCs base, base+4, base+8
  task automatic pkt(input logic [2:0] v, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [31:0] i2, input logic [31:0] base);
    v_ip    = v;
    insn_ip = {i2, i1, i0};
    addr_ip = {base + 32'd8, base + 32'd4, base};
  endtask

  task automatic idle();
    v_ip = '0; exc_ip = '0; intr_ip = '0; ecause_ip = '0; tval_ip = '0;
  endtask

  initial begin
    // Reset
    #22 rst_l = 1'b1;
    #1;
    chk("reset_valid", 64'(rec_valid), 64'd0);
    chk("reset_insn", 64'(rec_insn), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_dcnt", 64'(drop_cnt), 64'd0);

    // Full 3-slot packet streamed out with ready high
    rec_ready = 1'b1;
    pkt(3'b111, 32'h11, 32'h22, 32'h33, 32'h100);
    tick(); idle();
    chk("t1_valid0", 64'(rec_valid), 64'd1);
    chk("t1_insn0", 64'(rec_insn), 64'h11);
    chk("t1_addr0", 64'(rec_addr), 64'h100);
    tick();
    chk("t1_insn1", 64'(rec_insn), 64'h22);
    chk("t1_addr1", 64'(rec_addr), 64'h104);
    tick();
    chk("t1_insn2", 64'(rec_insn), 64'h33);
    chk("t1_addr2", 64'(rec_addr), 64'h108);
    tick();
    chk("t1_valid_end", 64'(rec_valid), 64'd0);

    // Gapped packet, exception only on slot 2
    rec_ready = 1'b0;
    pkt(3'b101, 32'hA0, 32'hB1, 32'hC2, 32'h200);
    exc_ip = 3'b100; ecause_ip = 5'd2; tval_ip = 32'hDEAD;
    tick(); idle();
    chk("t2_r0_insn", 64'(rec_insn), 64'hA0);
    chk("t2_r0_exc", 64'(rec_exc), 64'd0);
    chk("t2_r0_ecause", 64'(rec_ecause), 64'd0);
    chk("t2_r0_tval", 64'(rec_tval), 64'd0);
    rec_ready = 1'b1;
    tick();
    chk("t2_r1_insn", 64'(rec_insn), 64'hC2);
    chk("t2_r1_addr", 64'(rec_addr), 64'h208);
    chk("t2_r1_exc", 64'(rec_exc), 64'd1);
    chk("t2_r1_ecause", 64'(rec_ecause), 64'd2);
    chk("t2_r1_tval", 64'(rec_tval), 64'hDEAD);
    tick();
    chk("t2_empty", 64'(rec_valid), 64'd0);

    // Overflow: 3 + 3 fit, third 3-slot packet dropped, 2-slot fits exactly
    rec_ready = 1'b0;
    pkt(3'b111, 32'd1, 32'd2, 32'd3, 32'h300); tick();
    pkt(3'b111, 32'd4, 32'd5, 32'd6, 32'h310); tick();
    chk("t3_count6", 64'(dut.count_q), 64'd6);
    pkt(3'b111, 32'd7, 32'd8, 32'd9, 32'h320); tick();
    chk("t3_count_after_drop", 64'(dut.count_q), 64'd6);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_dcnt", 64'(drop_cnt), 64'd1);
    pkt(3'b011, 32'd10, 32'd11, 32'd99, 32'h330); tick();
    chk("t3_count8", 64'(dut.count_q), 64'd8);

    // Full FIFO: push+pop same cycle -> push dropped, then accepted next cycle
    rec_ready = 1'b1;
    pkt(3'b001, 32'd12, 32'd0, 32'd0, 32'h340); tick();
    chk("t4_count7", 64'(dut.count_q), 64'd7);
    chk("t4_dcnt", 64'(drop_cnt), 64'd2);
    chk("t4_head", 64'(rec_insn), 64'd2);
    tick(); idle();
    chk("t4_count_still7", 64'(dut.count_q), 64'd7);
    chk("t4_dcnt_same", 64'(drop_cnt), 64'd2);
    chk("t4_head3", 64'(rec_insn), 64'd3);
    // Queue now 3,4,5,6,10,11,12; drain three to leave four
    tick(); tick(); tick();
    chk("t5_count4", 64'(dut.count_q), 64'd4);

    // Backpressure stability
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_insn", 64'(rec_insn), 64'd6);
      chk("t5_hold_addr", 64'(rec_addr), 64'h318);
    end
    rec_ready = 1'b1;
    tick();
    chk("t5_order10", 64'(rec_insn), 64'd10);
    tick();
    chk("t5_order11", 64'(rec_insn), 64'd11);

    // Flush with a fitting packet and ready high: everything discarded
    flush = 1'b1;
    pkt(3'b111, 32'd20, 32'd21, 32'd22, 32'h400);
    tick(); idle(); flush = 1'b0;
    chk("t5_flush_count", 64'(dut.count_q), 64'd0);
    chk("t5_flush_valid", 64'(rec_valid), 64'd0);
    chk("t5_flush_dcnt", 64'(drop_cnt), 64'd2);
    chk("t5_flush_ovf", 64'(overflow), 64'd1);

    // Saturation: fill, then 16 dropped single-slot packets (2 + 16 -> 15)
    rec_ready = 1'b0;
    pkt(3'b111, 32'd30, 32'd31, 32'd32, 32'h500); tick();
    pkt(3'b111, 32'd33, 32'd34, 32'd35, 32'h510); tick();
    pkt(3'b011, 32'd36, 32'd37, 32'd0,  32'h520); tick();
    chk("t6_full", 64'(dut.count_q), 64'd8);
    pkt(3'b001, 32'd40, 32'd0, 32'd0, 32'h530);
    for (int i = 0; i < 16; i++) tick();
    chk("t6_sat", 64'(drop_cnt), 64'd15);
    chk("t6_head", 64'(rec_insn), 64'd30);
    idle(); drop_clr = 1'b1;
    tick();
    chk("t6_clr_dcnt", 64'(drop_cnt), 64'd0);
    chk("t6_clr_ovf", 64'(overflow), 64'd0);
    pkt(3'b001, 32'd41, 32'd0, 32'd0, 32'h540);
    tick(); idle(); drop_clr = 1'b0;
    chk("t6_clrdrop_dcnt", 64'(drop_cnt), 64'd1);
    chk("t6_clrdrop_ovf", 64'(overflow), 64'd1);

    // Asynchronous reset mid-operation
    @(posedge clk); #3 rst_l = 1'b0;
    #1;
    chk("t7_rst_valid", 64'(rec_valid), 64'd0);
    chk("t7_rst_insn", 64'(rec_insn), 64'd0);
    chk("t7_rst_dcnt", 64'(drop_cnt), 64'd0);
    chk("t7_rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk); rst_l = 1'b1;
    tick();
    chk("t7_post_count", 64'(dut.count_q), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
